inst_decode_stage: RTL and testbench
====================================

// Module: inst_decode_stage
// PURPOSE
//  RV32 decode pipeline stage between instruction memory and register-file/ALU stages.
//  Accepts the fetched word and its PC over a valid/ready handshake.
//  Splits the word into fields (funct7/rs2/rs1/funct3/rd/opcode), classifies the format,
//  and builds the sign-extended 32-bit immediate.
//  2-entry skid buffer: in_ready is driven from a flop, full throughput, 1-cycle latency.
// PARAMETERS
//  CNT_W  16  width of retired-decode counter dec_count
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   asynchronous, active-high reset
//  in_valid   in   1   upstream word valid
//  in_ready   out  1   stage can accept a word (registered)
//  in_pc      in   32  PC of in_inst
//  in_inst    in   32  raw instruction word
//  out_valid  out  1   decoded entry valid
//  out_ready  in   1   downstream accepts entry
//  out_pc     out  32  PC of decoded entry
//  opcode     out  7   inst[6:0]
//  rd         out  5   inst[11:7]
//  funct3     out  3   inst[14:12]
//  rs1        out  5   inst[19:15]
//  rs2        out  5   inst[24:20]
//  funct7     out  7   inst[31:25]
//  fmt        out  3   0=R 1=I 2=S 3=SB 4=U 5=UJ 7=ILLEGAL
//  imm        out  32  sign-extended immediate (0 for R/ILLEGAL)
//  dec_count  out  CNT_W  output handshakes since reset, wraps to 0
// BEHAVIOUR
//  Reset (async): state=EMPTY; out_valid=0; in_ready=1; dec_count=0; all data outputs 0.
//  Decode is combinational on in_inst; the decoded bundle (pc, fields, fmt, imm) is stored.
//  Format by opcode:
//   0x33 -> R; 0x03, 0x13, 0x67 -> I; 0x23 -> S; 0x63 -> SB; 0x37, 0x17 -> U; 0x6F -> UJ.
//   Any other opcode -> ILLEGAL. An ILLEGAL entry still flows through; it is never dropped.
//  Immediates:
//   I  = sext(inst[31:20])
//   S  = sext({inst[31:25],inst[11:7]})
//   SB = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//   U  = {inst[31:12],12'b0}
//   UJ = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//  Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   Inputs are sampled only on in_fire.
//   Output bundle is held stable while out_valid=1 and out_ready=0.
//  FSM (main register M drives outputs; skid register S):
//   EMPTY: in_fire -> load M, ONE.
//   ONE:   in_fire & out_fire  -> load M, stay ONE.
//          in_fire & !out_fire -> load S, go TWO, in_ready<=0.
//          !in_fire & out_fire -> EMPTY.
//   TWO:   out_fire -> M<=S, go ONE, in_ready<=1. No input accepted while in TWO.
//  out_valid = (state != EMPTY). in_ready = (state != TWO), from flop.
//  Latency: word accepted at edge N is on outputs after edge N; out_valid=1 in cycle N+1.
//  Ordering: strict FIFO; no entry is lost or duplicated.
//  dec_count increments by 1 per out_fire; wraps from 2^CNT_W-1 to 0.
//  Reset asserted mid-operation discards M and S immediately; no partial output.
// TESTING
//  add 0x002081B3, out_ready=1 -> next cycle fmt=0 funct7=00 rs2=2 rs1=1 funct3=0 rd=3 imm=0
//  addi 0xFFF00293 -> fmt=1 rd=5 rs1=0 imm=FFFFFFFF; sw 0x0020A423 -> fmt=2 rs1=1 rs2=2 funct3=2 imm=8
//  beq 0xFE208EE3 -> fmt=3 imm=FFFFFFFC; jal 0x008000EF -> fmt=5 rd=1 imm=8; 0xFFFFFFFF -> fmt=7 imm=0
//  Hold out_ready=0 while streaming 3 words at PC 0x28, 0x2C, 0x30:
//   -> in_ready drops after 2nd accept, 3rd word held off.
//   -> release out_ready: outputs in PC order 0x28, 0x2C, 0x30 with no loss.
//  11 back-to-back words with out_ready=1 -> one output per cycle, in_ready stays 1, dec_count=11
//  Assert reset while in TWO -> same cycle out_valid=0, in_ready=1, dec_count=0
//  CNT_W=4, 17 output handshakes -> dec_count=1

Source files
------------

// File: rtl/inst_decode_stage.sv
// RV32 decode stage: field split, format classification and immediate build,
// behind a 2-entry skid buffer with a registered in_ready.
module inst_decode_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [2:0]       fmt,
    output logic [31:0]      imm,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_SB  = 3'd3,
        FMT_U   = 3'd4,
        FMT_UJ  = 3'd5,
        FMT_ILL = 3'd7
    } fmt_t;

    // Raw word is kept; the fixed-position fields are re-sliced from it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } entry_t;

    state_t     state, next_state;
    entry_t     m_q, s_q, dec;
    logic       in_ready_q;
    logic       in_fire, out_fire;
    logic       load_m, load_s, m_from_s;
    logic [CNT_W-1:0] count_q;
    fmt_t       dec_fmt;
    logic [31:0] dec_imm;

    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        unique case (in_inst[6:0])
            7'h33: dec_fmt = FMT_R;
            7'h03, 7'h13, 7'h67: begin
                dec_fmt = FMT_I;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'h23: begin
                dec_fmt = FMT_S;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'h63: begin
                dec_fmt = FMT_SB;
                dec_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            7'h37, 7'h17: begin
                dec_fmt = FMT_U;
                dec_imm = {in_inst[31:12], 12'b0};
            end
            7'h6F: begin
                dec_fmt = FMT_UJ;
                dec_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign dec = '{pc: in_pc, inst: in_inst, fmt: dec_fmt, imm: dec_imm};

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        next_state = state;
        load_m     = 1'b0;
        load_s     = 1'b0;
        m_from_s   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_m     = 1'b1;
                    next_state = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_m = 1'b1;
                end else if (in_fire) begin
                    load_s     = 1'b1;
                    next_state = TWO;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    m_from_s   = 1'b1;
                    next_state = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != TWO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q     <= '0;
            s_q     <= '0;
            count_q <= '0;
        end else begin
            if (load_m)
                m_q <= dec;
            else if (m_from_s)
                m_q <= s_q;
            if (load_s)
                s_q <= dec;
            if (out_fire)
                count_q <= count_q + CNT_W'(1);
        end
    end

    assign out_pc    = m_q.pc;
    assign opcode    = m_q.inst[6:0];
    assign rd        = m_q.inst[11:7];
    assign funct3    = m_q.inst[14:12];
    assign rs1       = m_q.inst[19:15];
    assign rs2       = m_q.inst[24:20];
    assign funct7    = m_q.inst[31:25];
    assign fmt       = m_q.fmt;
    assign imm       = m_q.imm;
    assign dec_count = count_q;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: decode vectors, skid buffering,
// reset mid-operation, throughput and counter wrap (second instance, CNT_W=4).
module tb_inst_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [15:0] dec_count;

    logic        in_ready4, out_valid4;
    logic [31:0] out_pc4, imm4;
    logic [6:0]  opcode4, funct74;
    logic [4:0]  rd4, rs14, rs24;
    logic [2:0]  funct34, fmt4;
    logic [3:0]  dec_count4;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    inst_decode_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .funct7(funct7), .fmt(fmt), .imm(imm), .dec_count(dec_count)
    );

    inst_decode_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid4), .out_ready(out_ready),
        .out_pc(out_pc4), .opcode(opcode4), .rd(rd4), .funct3(funct34), .rs1(rs14),
        .rs2(rs24), .funct7(funct74), .fmt(fmt4), .imm(imm4), .dec_count(dec_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word with out_ready=1; after the edge it sits on the outputs.
    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_dec_count", {16'b0, dec_count}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_fmt", {29'b0, fmt}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // add x3,x1,x2
        send(32'h0000_0100, 32'h0020_81B3);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_pc", out_pc, 32'h100);
        chk("add_fmt", {29'b0, fmt}, 32'd0);
        chk("add_opcode", {25'b0, opcode}, 32'h33);
        chk("add_funct7", {25'b0, funct7}, 32'h00);
        chk("add_rs2", {27'b0, rs2}, 32'd2);
        chk("add_rs1", {27'b0, rs1}, 32'd1);
        chk("add_funct3", {29'b0, funct3}, 32'd0);
        chk("add_rd", {27'b0, rd}, 32'd3);
        chk("add_imm", imm, 32'd0);

        // addi x5,x0,-1
        send(32'h0000_0104, 32'hFFF0_0293);
        chk("addi_fmt", {29'b0, fmt}, 32'd1);
        chk("addi_rd", {27'b0, rd}, 32'd5);
        chk("addi_rs1", {27'b0, rs1}, 32'd0);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_pc", out_pc, 32'h104);

        // sw x2,8(x1)
        send(32'h0000_0108, 32'h0020_A423);
        chk("sw_fmt", {29'b0, fmt}, 32'd2);
        chk("sw_rs1", {27'b0, rs1}, 32'd1);
        chk("sw_rs2", {27'b0, rs2}, 32'd2);
        chk("sw_funct3", {29'b0, funct3}, 32'd2);
        chk("sw_imm", imm, 32'd8);

        // beq backwards by 4
        send(32'h0000_010C, 32'hFE20_8EE3);
        chk("beq_fmt", {29'b0, fmt}, 32'd3);
        chk("beq_imm", imm, 32'hFFFF_FFFC);

        // jal x1,+8
        send(32'h0000_0110, 32'h0080_00EF);
        chk("jal_fmt", {29'b0, fmt}, 32'd5);
        chk("jal_rd", {27'b0, rd}, 32'd1);
        chk("jal_imm", imm, 32'd8);

        // lui x5,0x12345
        send(32'h0000_0114, 32'h1234_52B7);
        chk("lui_fmt", {29'b0, fmt}, 32'd4);
        chk("lui_rd", {27'b0, rd}, 32'd5);
        chk("lui_imm", imm, 32'h1234_5000);

        // illegal opcode still flows through
        send(32'h0000_0118, 32'hFFFF_FFFF);
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_fmt", {29'b0, fmt}, 32'd7);
        chk("ill_imm", imm, 32'd0);
        chk("ill_pc", out_pc, 32'h118);
        tick();
        chk("drain7_valid", {31'b0, out_valid}, 32'd0);
        chk("drain7_count", {16'b0, dec_count}, 32'd7);

        // Skid: downstream stalled while three words arrive
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h28;
        in_inst   = 32'h0010_0093;
        tick();
        chk("skid1_in_ready", {31'b0, in_ready}, 32'd1);
        chk("skid1_pc", out_pc, 32'h28);
        in_pc     = 32'h2C;
        in_inst   = 32'h0020_0113;
        tick();
        chk("skid2_in_ready", {31'b0, in_ready}, 32'd0);
        chk("skid2_pc", out_pc, 32'h28);
        in_pc     = 32'h30;
        in_inst   = 32'h0030_0193;
        tick();
        chk("skid3_in_ready", {31'b0, in_ready}, 32'd0);
        chk("skid3_pc_hold", out_pc, 32'h28);
        chk("skid3_imm_hold", imm, 32'd1);
        chk("skid3_count", {16'b0, dec_count}, 32'd7);
        out_ready = 1'b1;
        tick();
        chk("rel1_pc", out_pc, 32'h2C);
        chk("rel1_imm", imm, 32'd2);
        chk("rel1_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rel2_pc", out_pc, 32'h30);
        chk("rel2_imm", imm, 32'd3);
        chk("rel2_valid", {31'b0, out_valid}, 32'd1);
        tick();
        chk("rel3_valid", {31'b0, out_valid}, 32'd0);
        chk("rel3_count", {16'b0, dec_count}, 32'd10);

        // Reset while holding two entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h40;
        in_inst   = 32'h0010_0093;
        tick();
        in_pc     = 32'h44;
        tick();
        in_valid  = 1'b0;
        chk("two_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_count", {16'b0, dec_count}, 32'd0);
        chk("midrst_pc", out_pc, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 11 back-to-back words at full throughput
        out_ready = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h200 + 32'(4 * (k - 1));
            in_inst  = 32'h0000_0013;
            tick();
            chk($sformatf("b2b%0d_pc", k), out_pc, 32'h200 + 32'(4 * (k - 1)));
            chk($sformatf("b2b%0d_in_ready", k), {31'b0, in_ready}, 32'd1);
            chk($sformatf("b2b%0d_count", k), {16'b0, dec_count}, 32'(k - 1));
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_drain_valid", {31'b0, out_valid}, 32'd0);
        chk("b2b_count", {16'b0, dec_count}, 32'd11);
        chk("b2b_count4", {28'b0, dec_count4}, 32'd11);

        // Six more handshakes: 17 total, narrow counter wraps to 1
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h300 + 32'(4 * k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_count16", {16'b0, dec_count}, 32'd17);
        chk("wrap_count4", {28'b0, dec_count4}, 32'd1);
        chk("wrap_pc4", out_pc4, 32'h314);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
